// File: rtl/fir_pkg.sv
// Shared constants and helpers for the transposed-form FIR family.
package fir_pkg;

    localparam int unsigned DIN_W_DEF  = 8;
    localparam int unsigned COEF_W_DEF = 10;
    localparam int unsigned NTAPS_DEF  = 65;
    localparam int unsigned SHIFT_DEF  = 9;
    localparam int unsigned DOUT_W_DEF = 16;
    localparam int unsigned DECIM_DEF  = 1;

    // Working width for the rounding/saturation helper; must exceed ACC_W + 1.
    localparam int unsigned RS_W = 64;

    typedef struct packed {
        logic                   sat;
        logic signed [RS_W-1:0] val;
    } rs_t;

    function automatic int unsigned fir_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Round half up, arithmetic shift right, clip to a dout_w-bit signed range.
    function automatic rs_t fir_round_sat(input logic signed [RS_W-1:0] acc,
                                          input int unsigned shift,
                                          input int unsigned dout_w);
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        rs_t res;
        r = acc;
        if (shift > 0) begin
            r = r + (RS_W'(1) << (shift - 1));
        end
        r  = r >>> shift;
        hi = (RS_W'(1) << (dout_w - 1)) - RS_W'(1);
        lo = ~hi;
        res.sat = (r > hi) || (r < lo);
        if (r > hi) begin
            res.val = hi;
        end else if (r < lo) begin
            res.val = lo;
        end else begin
            res.val = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-banked coefficient store: writes land in shadow, swap copies shadow to active.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS  = NTAPS_DEF,
    parameter int unsigned COEF_W = COEF_W_DEF,
    parameter int unsigned ADDR_W = fir_clog2(NTAPS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_we,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [COEF_W-1:0]       i_data,
    input  logic                    i_swap,
    output logic [NTAPS*COEF_W-1:0] o_active
);

    logic [COEF_W-1:0] r_shadow      [NTAPS];
    logic [COEF_W-1:0] r_active      [NTAPS];
    logic [COEF_W-1:0] w_shadow_next [NTAPS];

    // Swap copies the post-write shadow so a same-edge write is included.
    always_comb begin
        w_shadow_next = r_shadow;
        if (i_we && (32'(i_addr) < NTAPS)) begin
            w_shadow_next[i_addr] = i_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow <= '{default: '0};
            r_active <= '{default: '0};
        end else begin
            r_shadow <= w_shadow_next;
            if (i_swap) begin
                r_active <= w_shadow_next;
            end
        end
    end

    always_comb begin
        o_active = '0;
        for (int k = 0; k < NTAPS; k++) begin
            o_active[k*COEF_W +: COEF_W] = r_active[k];
        end
    end

endmodule

// File: rtl/fir_tf_prog_decim.sv
// Transposed-form FIR with double-banked programmable taps, valid-qualified input,
// integer decimation and a rounded/saturated registered output.
module fir_tf_prog_decim
    import fir_pkg::*;
#(
    parameter int unsigned DIN_W  = DIN_W_DEF,
    parameter int unsigned COEF_W = COEF_W_DEF,
    parameter int unsigned NTAPS  = NTAPS_DEF,
    parameter int unsigned ACC_W  = DIN_W + COEF_W + fir_clog2(NTAPS),
    parameter int unsigned SHIFT  = SHIFT_DEF,
    parameter int unsigned DOUT_W = DOUT_W_DEF,
    parameter int unsigned DECIM  = DECIM_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [DIN_W-1:0]            din,
    input  logic                        coef_we,
    input  logic [fir_clog2(NTAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]           coef_data,
    input  logic                        coef_swap,
    output logic                        out_valid,
    output logic [DOUT_W-1:0]           dout,
    output logic                        out_sat
);

    localparam int unsigned PH_W = (DECIM > 1) ? fir_clog2(DECIM) : 1;

    logic [NTAPS*COEF_W-1:0]   w_coef_flat;
    logic signed [COEF_W-1:0]  w_h    [NTAPS];
    logic signed [DIN_W-1:0]   w_x;
    logic signed [ACC_W-1:0]   w_prod [NTAPS];
    logic signed [ACC_W-1:0]   r_mac  [NTAPS];
    logic [PH_W-1:0]           r_phase;
    logic                      r_emit;
    rs_t                       w_rs;

    fir_coef_bank #(
        .NTAPS  (NTAPS),
        .COEF_W (COEF_W),
        .ADDR_W (fir_clog2(NTAPS))
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .i_we     (coef_we),
        .i_addr   (coef_addr),
        .i_data   (coef_data),
        .i_swap   (coef_swap),
        .o_active (w_coef_flat)
    );

    assign w_x = din;

    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            w_h[k]    = w_coef_flat[k*COEF_W +: COEF_W];
            w_prod[k] = ACC_W'(w_h[k]) * ACC_W'(w_x);
        end
    end

    // Bubbles freeze the whole chain so the delay line only advances on real samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_mac[k] <= '0;
            end
        end else if (in_valid) begin
            r_mac[NTAPS-1] <= w_prod[NTAPS-1];
            for (int k = 0; k < NTAPS - 1; k++) begin
                r_mac[k] <= r_mac[k+1] + w_prod[k];
            end
        end
    end

    assign w_rs = fir_round_sat(RS_W'(r_mac[0]), SHIFT, DOUT_W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase   <= '0;
            r_emit    <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            out_sat   <= 1'b0;
        end else begin
            r_emit    <= in_valid && (r_phase == '0);
            out_valid <= r_emit;
            if (r_emit) begin
                dout    <= DOUT_W'(w_rs.val);
                out_sat <= w_rs.sat;
            end
            if (in_valid) begin
                if (32'(r_phase) == DECIM - 1) begin
                    r_phase <= '0;
                end else begin
                    r_phase <= r_phase + PH_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_tf_prog_decim.sv
// Directed bench: three DUT configurations share one stimulus stream.
module tb_fir_tf_prog_decim;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 10;
    localparam int unsigned NT = 65;
    localparam int unsigned AW = 7;
    localparam int unsigned OW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] din;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          coef_swap;

    logic          a_ov, a_sat, d_ov, d_sat, r_ov, r_sat;
    logic [OW-1:0] a_dout, d_dout, r_dout;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    fir_tf_prog_decim #(.SHIFT(0), .DECIM(1)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .din(din), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
        .out_valid(a_ov), .dout(a_dout), .out_sat(a_sat)
    );

    fir_tf_prog_decim #(.SHIFT(0), .DECIM(4)) u_d (
        .clk(clk), .reset(reset), .in_valid(in_valid), .din(din), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
        .out_valid(d_ov), .dout(d_dout), .out_sat(d_sat)
    );

    fir_tf_prog_decim u_r (
        .clk(clk), .reset(reset), .in_valid(in_valid), .din(din), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
        .out_valid(r_ov), .dout(r_dout), .out_sat(r_sat)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic v, input int d, input logic sw = 1'b0);
        @(negedge clk);
        in_valid  = v;
        din       = DW'(d);
        coef_swap = sw;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        coef_swap = 1'b0;
    endtask

    task automatic wr(input int a, input int d, input logic sw = 1'b0);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = CW'(d);
        coef_swap = sw;
        @(posedge clk);
        #1;
        coef_we   = 1'b0;
        coef_swap = 1'b0;
    endtask

    task automatic load_all(input int mult, input int add);
        for (int k = 0; k < NT; k++) wr(k, k * mult + add);
    endtask

    task automatic swap_pulse();
        @(negedge clk);
        coef_swap = 1'b1;
        @(posedge clk);
        #1;
        coef_swap = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int xs [8] = '{1, -1, 2, -2, 3, -3, 127, -128};
        int ex [8] = '{1, 0, 1, -1, 2, -1, 64, -64};

        reset = 1'b1; in_valid = 1'b0; din = '0; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0; coef_swap = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", a_ov, 0);
        chk("rst_dout", $signed(a_dout), 0);
        chk("rst_out_sat", a_sat, 0);
        chk("rst_decim_out_valid", d_ov, 0);
        @(negedge clk) reset = 1'b1;

        // Shadow writes must not reach the active bank before a swap.
        load_all(1, 1);
        send(1, 1);
        send(1, 0);
        chk("shadow_only_dout", $signed(a_dout), 0);
        chk("shadow_only_valid", a_ov, 1);
        swap_pulse();

        send(1, 1);
        for (int k = 0; k <= 65; k++) begin
            send(1, 0);
            chk("impulse_dout", $signed(a_dout), (k < 65) ? k + 1 : 0);
            chk("impulse_valid", a_ov, 1);
        end

        send(1, 1);
        for (int k = 0; k <= 65; k++) begin
            send(0, 77);
            chk("bubble_dout", $signed(a_dout), (k < 65) ? k + 1 : 0);
            chk("bubble_valid", a_ov, 1);
            send(1, 0);
            chk("bubble_gap_valid", a_ov, 0);
            chk("bubble_hold_dout", $signed(a_dout), (k < 65) ? k + 1 : 0);
        end

        load_all(0, 1);
        swap_pulse();
        for (int n = 0; n < 70; n++) begin
            send(1, 1);
            if (n >= 1) chk("ramp_ones_dout", $signed(a_dout), (n < 65) ? n : 65);
        end
        load_all(0, 2);
        for (int j = 0; j < 70; j++) begin
            send(1, 1, j == 0);
            if (j >= 1) chk("swap_mid_dout", $signed(a_dout), 65 + ((j - 1 < 65) ? j - 1 : 65));
        end

        load_all(0, 511);
        swap_pulse();
        repeat (70) send(1, 127);
        chk("sat_pos_dout", $signed(a_dout), 32767);
        chk("sat_pos_flag", a_sat, 1);
        repeat (70) send(1, -128);
        chk("sat_neg_dout", $signed(a_dout), -32768);
        chk("sat_neg_flag", a_sat, 1);
        repeat (70) send(1, 0);
        chk("sat_clear_dout", $signed(a_dout), 0);
        chk("sat_clear_flag", a_sat, 0);

        send(1, 5);
        chk("pre_reset_valid", a_ov, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_valid", a_ov, 0);
        chk("async_reset_dout", $signed(a_dout), 0);
        chk("async_reset_decim_dout", $signed(d_dout), 0);
        @(negedge clk) reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            send(1, 100);
            if (n >= 1) begin
                chk("zero_coef_dout", $signed(a_dout), 0);
                chk("zero_coef_valid", a_ov, 1);
            end
        end

        // Write and swap on the same edge: the new tap must be live immediately after.
        reset_pulse();
        wr(0, 1, 1'b1);
        for (int n = 0; n <= 20; n++) begin
            send(1, n);
            if (n >= 1) begin
                chk("decim_valid", d_ov, ((n - 1) % 4 == 0) ? 1 : 0);
                chk("decim_dout", $signed(d_dout), 4 * ((n - 1) / 4));
                chk("we_swap_same_edge", $signed(a_dout), n - 1);
            end
        end

        reset_pulse();
        wr(0, 256);
        swap_pulse();
        for (int i = 0; i < 8; i++) begin
            send(1, xs[i]);
            if (i > 0) chk("round_dout", $signed(r_dout), ex[i-1]);
        end
        send(0, 0);
        chk("round_dout_last", $signed(r_dout), ex[7]);
        chk("round_sat_flag", r_sat, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
